lcd_read_cycle: RTL and testbench

- Generates the complete HD44780-style LCD read transaction (RW=1) over the 4-bit bus: RS/RW setup, two E pulses, upper nibble first, with gap and hold timing.
- Samples both nibbles and returns one byte: the busy flag plus address counter when RS=0, or a data RAM byte when RS=1.
- Sits beside the LCD write-enable pulse generator in the LCD controller; the top-level arbiter muxes E/RW/RS between the two blocks.

---
 rtl/lcd_read_cycle.sv | 158 +++++++++++++++
 tb/tb_lcd_read_cycle.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_cycle.sv
// lcd_read_cycle
//   HD44780-style 4-bit read transaction generator (RW=1). Drives RS/RW
//   setup, two E pulses (upper nibble first) with a low gap between them,
//   and a hold after the last E fall. It samples DB[7:4] on the last
//   E-high cycle of each pulse and returns the assembled byte.
//
// Ports
//   Clock               system clock (50 MHz)
//   iReset              async reset, active low
//   iStart              read request, sampled only in IDLE
//   iRegisterSelect     RS for the read (0 = busy flag/address, 1 = data)
//   iLCD_Data[3:0]      LCD DB[7:4] from the pad
//   oLCD_Enabled        LCD E
//   oLCD_ReadWrite      LCD RW
//   oLCD_RegisterSelect LCD RS
//   oBusOwn             read owns the bus; FPGA data drivers must be tri-stated
//   oBusy               not IDLE
//   oReadData[7:0]      {upper, lower} nibbles
//   oReadValid          one-cycle strobe in DONE
//   oBusyFlag           bit 7 of the last RS=0 read
module lcd_read_cycle #(
  parameter int SETUP_CYCLES = 2,
  parameter int HIGH_CYCLES  = 12,
  parameter int GAP_CYCLES   = 50,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       Clock,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iRegisterSelect,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_Enabled,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_RegisterSelect,
  output logic       oBusOwn,
  output logic       oBusy,
  output logic [7:0] oReadData,
  output logic       oReadValid,
  output logic       oBusyFlag
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH1 = 3'd2,
    GAP   = 3'd3,
    HIGH2 = 3'd4,
    HOLD  = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Counter reload values: a state of N cycles counts N-1 down to 0.
  localparam logic [7:0] L_SETUP = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] L_HIGH  = 8'(HIGH_CYCLES - 1);
  localparam logic [7:0] L_GAP   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] L_HOLD  = 8'(HOLD_CYCLES - 1);

  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_load;
  logic       r_rs;
  logic       w_rs;
  logic       w_cnt_zero;
  logic       w_bus_phase;

  logic       r_e, r_rw, r_rs_out, r_busown, r_busy, r_valid, r_bf;
  logic [7:0] r_data;

  assign w_cnt_zero = (r_cnt == 8'd0);

  // RS seen by the output register on the T0 edge is the live input; after
  // that it is the latched copy, so mid-transaction changes are ignored.
  assign w_rs = (r_state == IDLE) ? iRegisterSelect : r_rs;

  always_ff @(posedge Clock or negedge iReset) begin
    if (!iReset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= w_load;
      else if (!w_cnt_zero)
        r_cnt <= r_cnt - 8'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (iStart)     w_next = SETUP;
      SETUP:   if (w_cnt_zero) w_next = HIGH1;
      HIGH1:   if (w_cnt_zero) w_next = GAP;
      GAP:     if (w_cnt_zero) w_next = HIGH2;
      HIGH2:   if (w_cnt_zero) w_next = HOLD;
      HOLD:    if (w_cnt_zero) w_next = DONE;
      DONE:                    w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load = 8'd0;
    case (w_next)
      SETUP:        w_load = L_SETUP;
      HIGH1, HIGH2: w_load = L_HIGH;
      GAP:          w_load = L_GAP;
      HOLD:         w_load = L_HOLD;
      default:      w_load = 8'd0;
    endcase
  end

  // SETUP..HOLD: RW high and the bus belongs to the LCD.
  assign w_bus_phase = (w_next == SETUP) || (w_next == HIGH1) || (w_next == GAP) ||
                       (w_next == HIGH2) || (w_next == HOLD);

  // Outputs are registered from the next state, so they line up with the
  // state they describe and nothing combinational reaches the pins.
  always_ff @(posedge Clock or negedge iReset) begin
    if (!iReset) begin
      r_rs     <= 1'b0;
      r_e      <= 1'b0;
      r_rw     <= 1'b0;
      r_rs_out <= 1'b0;
      r_busown <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_bf     <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      if (r_state == IDLE && iStart)
        r_rs <= iRegisterSelect;
      r_e      <= (w_next == HIGH1) || (w_next == HIGH2);
      r_rw     <= w_bus_phase;
      r_rs_out <= w_bus_phase & w_rs;
      r_busown <= w_bus_phase;
      r_busy   <= (w_next != IDLE);
      r_valid  <= (w_next == DONE);
      // Sample on the edge that ends each E pulse (last E-high cycle).
      if (r_state == HIGH1 && w_cnt_zero)
        r_data[7:4] <= iLCD_Data;
      if (r_state == HIGH2 && w_cnt_zero)
        r_data[3:0] <= iLCD_Data;
      // Upper nibble is already in place by the time DONE is entered.
      if (w_next == DONE && !r_rs)
        r_bf <= r_data[7];
    end
  end

  assign oLCD_Enabled        = r_e;
  assign oLCD_ReadWrite      = r_rw;
  assign oLCD_RegisterSelect = r_rs_out;
  assign oBusOwn             = r_busown;
  assign oBusy               = r_busy;
  assign oReadData           = r_data;
  assign oReadValid          = r_valid;
  assign oBusyFlag           = r_bf;

endmodule

// File: tb/tb_lcd_read_cycle.sv
// Testbench for lcd_read_cycle: a bus model answers each E pulse with the
// nibble only on the last E-high cycle (complement otherwise); expected
// bytes go into a scoreboard queue when a read is started and are popped
// when oReadValid fires.
module tb_lcd_read_cycle;
  localparam int HIGH = 12;

  logic       Clock = 1'b0;
  logic       iReset, iStart, iRegisterSelect;
  logic [3:0] iLCD_Data = 4'h0;
  logic       oLCD_Enabled, oLCD_ReadWrite, oLCD_RegisterSelect;
  logic       oBusOwn, oBusy, oReadValid, oBusyFlag;
  logic [7:0] oReadData;

  lcd_read_cycle dut (
    .Clock(Clock), .iReset(iReset), .iStart(iStart),
    .iRegisterSelect(iRegisterSelect), .iLCD_Data(iLCD_Data),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_RegisterSelect(oLCD_RegisterSelect), .oBusOwn(oBusOwn),
    .oBusy(oBusy), .oReadData(oReadData), .oReadValid(oReadValid),
    .oBusyFlag(oBusyFlag)
  );

  always #10 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  int e_run = 0;
  int pulse_idx = 0;
  logic [3:0] nib_hi = 4'h0, nib_lo = 4'h0, cur;
  logic       exp_bf = 1'b0;
  logic [8:0] sb_q[$];   // {byte, busy flag}
  logic [8:0] sb_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic rs, input logic [3:0] hi, input logic [3:0] lo);
    if (!rs) exp_bf = hi[3];
    sb_q.push_back({hi, lo, exp_bf});
  endtask

  // Bus model + scoreboard consumer
  always @(negedge Clock) begin
    if (!iReset) begin
      e_run = 0;
      pulse_idx = 0;
    end else begin
      if (!oBusOwn) pulse_idx = 0;
      if (oLCD_Enabled) begin
        e_run++;
        if (e_run == 1) pulse_idx++;
        chk("e_implies_rw", oLCD_ReadWrite, 1);
      end else
        e_run = 0;
      cur = (pulse_idx == 1) ? nib_hi : nib_lo;
      iLCD_Data = (oLCD_Enabled && e_run == HIGH) ? cur : ~cur;
      if (oReadValid) begin
        valid_cnt++;
        if (sb_q.size() == 0)
          chk("spurious_valid", oReadValid, 0);
        else begin
          sb_e = sb_q.pop_front();
          chk("rd_data", oReadData, sb_e[8:1]);
          chk("busy_flag", oBusyFlag, sb_e[0]);
        end
      end
    end
  end

  task automatic run_read(input logic rs, input logic [3:0] hi, input logic [3:0] lo, input bit poke);
    int vcyc, rise1, rise2, ehigh, rsbad, rwbad, obad, v0;
    logic pe;
    nib_hi = hi; nib_lo = lo;
    push_exp(rs, hi, lo);
    v0 = valid_cnt;
    @(negedge Clock);
    iRegisterSelect = rs;
    iStart = 1'b1;
    @(posedge Clock);  // T0
    vcyc = -1; rise1 = -1; rise2 = -1; ehigh = 0; rsbad = 0; rwbad = 0; obad = 0; pe = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge Clock);  // in the cycle following edge T0+c
      if (c == 0) begin iStart = 1'b0; iRegisterSelect = ~rs; end
      if (poke && c == 29) iStart = 1'b1;
      if (poke && c == 30) iStart = 1'b0;
      if (oLCD_Enabled) begin
        ehigh++;
        if (!pe) begin
          if (rise1 < 0) rise1 = c;
          else if (rise2 < 0) rise2 = c;
        end
      end
      pe = oLCD_Enabled;
      if (c <= 76) begin
        if (oLCD_RegisterSelect !== rs) rsbad++;
        if (oLCD_ReadWrite !== 1'b1) rwbad++;
        if (oBusOwn !== 1'b1 || oBusy !== 1'b1) obad++;
      end
      if (oReadValid && vcyc < 0) begin
        vcyc = c;
        chk("done_rw", oLCD_ReadWrite, 0);
        chk("done_busown", oBusOwn, 0);
        chk("done_busy", oBusy, 1);
      end
      if (c == 78) chk("busy_after_done", oBusy, 0);
    end
    chk("valid_latency", vcyc, 77);
    chk("e1_rise", rise1, 2);
    chk("e2_rise", rise2, 64);
    chk("e_high_cycles", ehigh, 2 * HIGH);
    chk("rs_stable", rsbad, 0);
    chk("rw_high", rwbad, 0);
    chk("busown_busy", obad, 0);
    chk("valid_count", valid_cnt - v0, 1);
  endtask

  initial begin
    int eh, v0, n;
    int vt[3];
    logic [3:0] bh[3], bl[3];
    logic       brs[3];

    iReset = 1'b0; iStart = 1'b0; iRegisterSelect = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    // Reset state
    chk("rst_e", oLCD_Enabled, 0);
    chk("rst_rw", oLCD_ReadWrite, 0);
    chk("rst_rs", oLCD_RegisterSelect, 0);
    chk("rst_busown", oBusOwn, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_valid", oReadValid, 0);
    chk("rst_bf", oBusyFlag, 0);
    chk("rst_data", oReadData, 8'h00);
    iReset = 1'b1;
    eh = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (oLCD_Enabled || oBusy || oReadValid) eh++;
    end
    chk("idle_quiet", eh, 0);

    run_read(1'b0, 4'h8, 4'h3, 1'b0);  // 0x83, busy flag 1
    run_read(1'b1, 4'h4, 4'h1, 1'b0);  // 0x41, busy flag holds
    run_read(1'b1, 4'hC, 4'h7, 1'b1);  // second iStart mid-read ignored

    // Async reset in the middle of the first E pulse (T0+10)
    nib_hi = 4'h9; nib_lo = 4'h6;
    v0 = valid_cnt;
    @(negedge Clock);
    iRegisterSelect = 1'b0;
    iStart = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    iStart = 1'b0;
    repeat (10) @(posedge Clock);
    #1;
    chk("pre_rst_e", oLCD_Enabled, 1);
    iReset = 1'b0;
    #1;
    chk("arst_e", oLCD_Enabled, 0);
    chk("arst_rw", oLCD_ReadWrite, 0);
    chk("arst_busown", oBusOwn, 0);
    chk("arst_busy", oBusy, 0);
    chk("arst_data", oReadData, 8'h00);
    chk("arst_bf", oBusyFlag, 0);
    exp_bf = 1'b0;
    repeat (3) @(negedge Clock);
    iReset = 1'b1;
    repeat (100) @(negedge Clock);
    chk("arst_no_valid", valid_cnt - v0, 0);
    run_read(1'b0, 4'h2, 4'h5, 1'b0);  // clean cycle after reset

    // iStart held high: three back-to-back reads
    bh = '{4'h5, 4'hA, 4'hE};
    bl = '{4'hB, 4'h0, 4'h9};
    brs = '{1'b0, 1'b1, 1'b0};
    n = 0;
    nib_hi = bh[0]; nib_lo = bl[0];
    push_exp(brs[0], bh[0], bl[0]);
    @(negedge Clock);
    iRegisterSelect = brs[0];
    iStart = 1'b1;
    for (int c = 0; c < 400 && n < 3; c++) begin
      @(negedge Clock);
      if (oReadValid) begin
        vt[n] = c;
        n++;
        if (n < 3) begin
          nib_hi = bh[n]; nib_lo = bl[n];
          iRegisterSelect = brs[n];
          push_exp(brs[n], bh[n], bl[n]);
        end else
          iStart = 1'b0;
      end
    end
    chk("b2b_count", n, 3);
    // DONE + one IDLE cycle between reads: a 79-cycle strobe period.
    if (n == 3) begin
      chk("b2b_gap1", vt[1] - vt[0], 79);
      chk("b2b_gap2", vt[2] - vt[1], 79);
    end
    repeat (100) @(negedge Clock);
    chk("b2b_stopped", oBusy, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
